// File: rtl/time_display_driver.sv
// time_display_driver: binary h/m/s to BCD via subtract-10 FSM, scanned onto an 8-digit
// common-anode seven-segment display with a once-per-frame input snapshot.
module time_display_driver #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit HOUR_LZ_BLANK = 1'b1
) (
    input  logic       clk_100MHz,
    input  logic       resetn,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       conv_busy
);
    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [2:0] {IDLE, LOAD, CONV_H, CONV_M, CONV_S, UPDATE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    scan_q;
    logic          pend_q;
    logic [4:0]    h_q;
    logic [5:0]    m_q, s_q;
    logic [2:0]    t_q;
    // Index order matches the scan slot: 0/1 sec, 2/3 min, 4/5 hour, 6/7 always zero.
    logic [3:0]    bcd_q  [8];
    logic [3:0]    disp_q [8];

    logic          tick, start_req, ge10, blank, lz;
    logic [5:0]    cur;
    logic [3:0]    dig;
    logic [6:0]    code, seg_d;
    logic [7:0]    an_d;
    logic          dp_d;

    assign tick      = cnt_q == CW'(REFRESH_DIV - 1);
    assign start_req = pend_q | (tick & (scan_q == 3'd7));
    assign cur       = (state_q == CONV_H) ? {1'b0, h_q} : (state_q == CONV_M) ? m_q : s_q;
    assign ge10      = cur >= 6'd10;
    assign conv_busy = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_req ? LOAD : IDLE;
            LOAD:    state_d = CONV_H;
            CONV_H:  state_d = ge10 ? CONV_H : CONV_M;
            CONV_M:  state_d = ge10 ? CONV_M : CONV_S;
            CONV_S:  state_d = ge10 ? CONV_S : UPDATE;
            default: state_d = IDLE;
        endcase
    end

    assign dig   = disp_q[scan_q];
    assign blank = scan_q[2] & scan_q[1];
    assign lz    = HOUR_LZ_BLANK && (scan_q == 3'd5) && (disp_q[5] == 4'd0);

    always_comb begin
        code = 7'h7F;
        case (dig)
            4'd0: code = 7'b1000000;
            4'd1: code = 7'b1111001;
            4'd2: code = 7'b0100100;
            4'd3: code = 7'b0110000;
            4'd4: code = 7'b0011001;
            4'd5: code = 7'b0010010;
            4'd6: code = 7'b0000010;
            4'd7: code = 7'b1111000;
            4'd8: code = 7'b0000000;
            4'd9: code = 7'b0010000;
            default: code = 7'h7F;
        endcase
    end

    assign seg_d = (blank | lz) ? 7'h7F : code;
    assign an_d  = blank ? 8'hFF : ~(8'd1 << scan_q);
    assign dp_d  = !((scan_q == 3'd2) || (scan_q == 3'd4));

    always_ff @(posedge clk_100MHz or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            scan_q  <= '0;
            pend_q  <= 1'b1;
            h_q     <= '0;
            m_q     <= '0;
            s_q     <= '0;
            t_q     <= '0;
            bcd_q   <= '{default: '0};
            disp_q  <= '{default: '0};
            an      <= 8'hFF;
            seg     <= 7'h7F;
            dp      <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            scan_q  <= tick ? scan_q + 3'd1 : scan_q;
            pend_q  <= 1'b0;
            an      <= an_d;
            seg     <= seg_d;
            dp      <= dp_d;
            case (state_q)
                LOAD: begin
                    h_q <= hour_in;
                    m_q <= min_in;
                    s_q <= sec_in;
                    t_q <= '0;
                end
                CONV_H: begin
                    if (ge10) begin
                        h_q <= h_q - 5'd10;
                        t_q <= t_q + 3'd1;
                    end else begin
                        bcd_q[5] <= {1'b0, t_q};
                        bcd_q[4] <= h_q[3:0];
                        t_q      <= '0;
                    end
                end
                CONV_M: begin
                    if (ge10) begin
                        m_q <= m_q - 6'd10;
                        t_q <= t_q + 3'd1;
                    end else begin
                        bcd_q[3] <= {1'b0, t_q};
                        bcd_q[2] <= m_q[3:0];
                        t_q      <= '0;
                    end
                end
                CONV_S: begin
                    if (ge10) begin
                        s_q <= s_q - 6'd10;
                        t_q <= t_q + 3'd1;
                    end else begin
                        bcd_q[1] <= {1'b0, t_q};
                        bcd_q[0] <= s_q[3:0];
                        t_q      <= '0;
                    end
                end
                UPDATE: disp_q <= bcd_q;
                default: ;
            endcase
        end
    end
endmodule
